// File: rtl/nbody_pair_sched.sv
// Pair scheduler for the getAccl pipeline: issues every ordered (i,j), j!=i, one per cycle,
// and delays a matching {valid,i,first,last} tag so results can be attributed downstream.
module nbody_pair_sched #(
    parameter int MAX_BODIES = 256,
    parameter int IDX_W      = 8,
    parameter int LATENCY    = 122,
    parameter int MEM_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   num_bodies,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr_i,
    output logic [IDX_W-1:0] rd_addr_j,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_i,
    output logic             res_first,
    output logic             res_last
);

    localparam int DEPTH = MEM_LAT + LATENCY;
    localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(MAX_BODIES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             first;
        logic             last;
    } tag_t;

    state_t           state_q, state_d;
    logic [IDX_W:0]   n_q, n_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic             rd_en_q, rd_en_d;
    logic             first_q, first_d, last_q, last_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [IDX_W:0]   n_clamped, nm1, nm2, cur_last_j;
    logic [IDX_W-1:0] nxt_i, nxt_j;
    logic             nxt_first, nxt_last, is_final, drain_hit;

    tag_t tag_in;
    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    assign nm1 = n_q - 1'b1;
    assign nm2 = n_q - 2'd2;

    // The tail tag is checked one stage early so FIN coincides with the final result on res_*.
    assign drain_hit = pipe_q[DEPTH-2].valid && pipe_q[DEPTH-2].last &&
                       ({1'b0, pipe_q[DEPTH-2].idx} == nm1);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        i_d       = i_q;
        j_d       = j_q;
        rd_en_d   = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        n_clamped  = (num_bodies > MAX_N) ? MAX_N : num_bodies;
        cur_last_j = ({1'b0, i_q} == nm1) ? nm2 : nm1;
        is_final   = ({1'b0, i_q} == nm1) && ({1'b0, j_q} == nm2);

        // Advance to the next pair, stepping over j==i without a bubble.
        if ({1'b0, j_q} == cur_last_j) begin
            nxt_i = i_q + 1'b1;
            nxt_j = '0;
        end else begin
            nxt_i = i_q;
            nxt_j = j_q + 1'b1;
            if (nxt_j == i_q) begin
                nxt_j = j_q + 2'd2;
            end
        end
        nxt_first = (nxt_i == '0) ? (nxt_j == IDX_W'(1)) : (nxt_j == '0);
        nxt_last  = ({1'b0, nxt_i} == nm1) ? ({1'b0, nxt_j} == nm2)
                                           : ({1'b0, nxt_j} == nm1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d    = n_clamped;
                    busy_d = 1'b1;
                    if (n_clamped >= 2'd2) begin
                        state_d = ISSUE;
                        i_d     = '0;
                        j_d     = IDX_W'(1);
                        rd_en_d = 1'b1;
                        first_d = 1'b1;
                        last_d  = (n_clamped == 2'd2);
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (is_final) begin
                    state_d = DRAIN;
                end else begin
                    i_d     = nxt_i;
                    j_d     = nxt_j;
                    rd_en_d = 1'b1;
                    first_d = nxt_first;
                    last_d  = nxt_last;
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (drain_hit) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tag_in = {rd_en_q, i_q, first_q, last_q};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_d[gi] = tag_in;
            end else begin : g_body
                assign pipe_d[gi] = pipe_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rd_en_q <= rd_en_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pipe_q  <= pipe_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_i = i_q;
    assign rd_addr_j = j_q;
    assign res_valid = pipe_q[DEPTH-1].valid;
    assign res_i     = pipe_q[DEPTH-1].idx;
    assign res_first = pipe_q[DEPTH-1].first;
    assign res_last  = pipe_q[DEPTH-1].last;

endmodule

// File: tb/tb_nbody_pair_sched.sv
// Bench for nbody_pair_sched: table of sweeps checked by a pair/tag scoreboard,
// plus hand sequences for mid-sweep reset and a small getAccl alignment model.
module tb_nbody_pair_sched;

    localparam int IDX_W = 8;
    localparam int PIPE  = 123;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W:0]   num_bodies = '0;
    logic             busy, done, rd_en, res_valid, res_first, res_last;
    logic [IDX_W-1:0] rd_addr_i, rd_addr_j, res_i;

    nbody_pair_sched #(
        .MAX_BODIES(256), .IDX_W(IDX_W), .LATENCY(122), .MEM_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j),
        .res_valid(res_valid), .res_i(res_i),
        .res_first(res_first), .res_last(res_last)
    );

    always #5 clk = ~clk;

    typedef struct {int i; int j; bit first; bit last;} pair_t;
    typedef struct {int i; bit first; bit last; int due;} tag_t;
    typedef struct {real ax; real ay; int due;} acc_t;
    typedef struct {int n; int done_off; bit repulse; bit acc;} vec_t;

    pair_t exp_rd[$];
    tag_t  exp_res[$];
    acc_t  acc_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int rd_count, first_rd, last_rd, res_count, done_count, done_cyc, busy_count;
    bit acc_chk = 1'b0;

    real bx[2] = '{10.0, 0.0};
    real by[2] = '{20.0, 0.0};
    real bm[2] = '{500.0, 400.0};
    real ref_ax[2] = '{-0.35777087639996635, 0.4472135954999579};
    real ref_ay[2] = '{-0.7155417527999327, 0.8944271909999159};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp);
        real d, m;
        d = act - exp;
        if (d < 0.0) d = -d;
        m = (exp < 0.0) ? -exp : exp;
        n_tests++;
        if (d > 1.0e-9 * m) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %g, expected %g", name, cyc, act, exp);
        end
    endtask

    // Expected pair list in i-major order; first/last derived from neighbours in the list.
    task automatic build_expected(input int n);
        pair_t p;
        int sz;
        exp_rd.delete();
        exp_res.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    p = '{i, j, 1'b0, 1'b0};
                    exp_rd.push_back(p);
                end
            end
        end
        sz = exp_rd.size();
        for (int k = 0; k < sz; k++) begin
            exp_rd[k].first = (k == 0) || (exp_rd[k-1].i != exp_rd[k].i);
            exp_rd[k].last  = (k == sz-1) || (exp_rd[k+1].i != exp_rd[k].i);
        end
    endtask

    task automatic clear_counts();
        rd_count = 0; first_rd = -1; last_rd = -1; res_count = 0;
        done_count = 0; done_cyc = -1; busy_count = 0;
    endtask

    pair_t mon_p;
    tag_t  mon_t;
    acc_t  mon_a;
    always @(negedge clk) begin
        if (rd_en) begin
            rd_count++;
            if (rd_count == 1) first_rd = cyc;
            last_rd = cyc;
            if (exp_rd.size() == 0) begin
                chk("rd_unexpected", int'(rd_en), 0);
            end else begin
                mon_p = exp_rd.pop_front();
                chk("rd_pair", {rd_addr_i, rd_addr_j}, {mon_p.i[7:0], mon_p.j[7:0]});
                exp_res.push_back('{mon_p.i, mon_p.first, mon_p.last, cyc + PIPE});
            end
            // getAccl model: memory data one cycle after the address, result 122 cycles later.
            if (acc_chk && rd_addr_i < 2 && rd_addr_j < 2) begin
                real dx, dy, r2, r3;
                dx = bx[rd_addr_j] - bx[rd_addr_i];
                dy = by[rd_addr_j] - by[rd_addr_i];
                r2 = dx*dx + dy*dy;
                r3 = r2 * $sqrt(r2);
                acc_q.push_back('{bm[rd_addr_j]*dx/r3, bm[rd_addr_j]*dy/r3, cyc + 1 + 122});
            end
        end
        if (res_valid) begin
            res_count++;
            if (exp_res.size() == 0) begin
                chk("res_unexpected", int'(res_valid), 0);
            end else begin
                mon_t = exp_res.pop_front();
                chk("res_tag", {res_i, res_first, res_last}, {mon_t.i[7:0], mon_t.first, mon_t.last});
                chk("res_latency", cyc, mon_t.due);
            end
            if (acc_chk) begin
                if (acc_q.size() == 0 || res_i > 1) begin
                    chk("acc_missing", int'(res_valid), 0);
                end else begin
                    mon_a = acc_q.pop_front();
                    chk("acc_latency", cyc, mon_a.due);
                    chk_real("acc_ax", mon_a.ax, ref_ax[res_i]);
                    chk_real("acc_ay", mon_a.ay, ref_ay[res_i]);
                end
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (busy) busy_count++;
    end

    task automatic run_sweep(input int n, input int done_off, input bit repulse, input bit acc);
        int s, pairs;
        pairs = n * (n - 1);
        build_expected(n);
        acc_q.delete();
        acc_chk = acc;
        clear_counts();
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        num_bodies = n[IDX_W:0];
        @(negedge clk);
        start = 1'b0;
        num_bodies = (IDX_W+1)'($urandom_range(0, 511));
        if (repulse) begin
            while (cyc < s + 5) @(negedge clk);
            start = 1'b1; num_bodies = 2;
            @(negedge clk);
            start = 1'b0;
            while (cyc < s + pairs + 20) @(negedge clk);
            start = 1'b1; num_bodies = 9;
            @(negedge clk);
            start = 1'b0;
        end
        while (done_count == 0 && cyc < s + done_off + 50) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("done_time", done_cyc - s, done_off);
        chk("done_count", done_count, 1);
        chk("rd_count", rd_count, pairs);
        if (pairs > 0) begin
            chk("rd_first", first_rd - s, 1);
            chk("rd_gapless", last_rd - first_rd + 1, pairs);
        end
        chk("res_count", res_count, pairs);
        chk("busy_cycles", busy_count, done_off - 1);
        chk("sb_leftover", exp_rd.size() + exp_res.size(), 0);
        acc_chk = 1'b0;
        $display("[TB] sweep N=%0d pairs=%0d done@+%0d results=%0d", n, rd_count, done_cyc - s, res_count);
    endtask

    vec_t vecs[7];

    initial begin
        int s;
        vecs[0] = '{3, 130, 1'b0, 1'b0};
        vecs[1] = '{2, 126, 1'b0, 1'b1};
        vecs[2] = '{1, 2, 1'b0, 1'b0};
        vecs[3] = '{0, 2, 1'b0, 1'b0};
        vecs[4] = '{4, 136, 1'b1, 1'b0};
        vecs[5] = '{5, 144, 1'b0, 1'b0};
        vecs[6] = '{7, 166, 1'b0, 1'b0};
        clear_counts();

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, rd_en, res_valid, res_first, res_last}, 0);
        chk("reset_addr", {rd_addr_i, rd_addr_j, res_i}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", {busy, done, rd_en}, 0);

        for (int v = 0; v < 7; v++) begin
            run_sweep(vecs[v].n, vecs[v].done_off, vecs[v].repulse, vecs[v].acc);
        end

        // Reset 50 cycles into an N=8 sweep; nothing may leak out afterwards.
        build_expected(8);
        clear_counts();
        @(negedge clk);
        s = cyc;
        start = 1'b1; num_bodies = 8;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 50) @(negedge clk);
        #1;
        exp_rd.delete();
        exp_res.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {busy, done, rd_en, res_valid, res_first, res_last,
                            rd_addr_i, rd_addr_j, res_i}, 0);
        #1;
        clear_counts();
        repeat (200) @(negedge clk);
        chk("post_rst_res", res_count, 0);
        chk("post_rst_rd", rd_count, 0);
        chk("post_rst_done", done_count, 0);
        $display("[TB] reset mid-sweep N=8 at +50, quiet window res=%0d rd=%0d", res_count, rd_count);

        run_sweep(8, 180, 1'b0, 1'b0);
        run_sweep(256, 65404, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
